// File: rtl/mac_seq.sv
// Dot-product sequencer around an external mac: streams N_TERMS operand pairs from two
// synchronous-read memories, then scales and saturates the accumulator to a signed 8-bit result.
module mac_seq #(
   parameter int N_TERMS    = 32,
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 8,
   parameter int ACC_W      = 26,
   parameter int FRAC_SHIFT = 7
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   output logic                     busy,
   output logic [ADDR_W-1:0]        addr,
   input  logic signed [DATA_W-1:0] x_rd,
   input  logic signed [DATA_W-1:0] w_rd,
   output logic signed [DATA_W-1:0] mac_a,
   output logic signed [DATA_W-1:0] mac_b,
   output logic                     mac_clr_n,
   input  logic signed [ACC_W-1:0]  mac_acc,
   output logic signed [7:0]        result,
   output logic                     done
);

   typedef enum logic [2:0] {IDLE, RUN, WAIT, SAT, DONE} state_t;

   localparam logic [ADDR_W-1:0]       LAST_ADDR = ADDR_W'(N_TERMS - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'(127);
   localparam logic signed [ACC_W-1:0] SAT_MIN   = ACC_W'(-128);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic              valid_d;

   // Floor-scale the accumulator, then clamp into the signed 8-bit range.
   function automatic logic signed [7:0] sat8(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] s;
      s = acc >>> FRAC_SHIFT;
      if (s > SAT_MAX)
         return 8'sh7f;
      else if (s < SAT_MIN)
         return -8'sd128;
      else
         return s[7:0];
   endfunction

   always_comb begin
      state_nxt = state;
      addr_nxt  = addr;
      case (state)
         IDLE: begin
            addr_nxt = '0;
            if (start)
               state_nxt = RUN;
         end
         RUN: begin
            if (addr == LAST_ADDR) begin
               addr_nxt  = '0;
               state_nxt = WAIT;
            end else begin
               addr_nxt = addr + 1'b1;
            end
         end
         WAIT:    state_nxt = SAT;
         SAT:     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         addr    <= '0;
         valid_d <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
      end else begin
         state   <= state_nxt;
         addr    <= addr_nxt;
         // Memory data lags the address by one cycle, so the RUN flag is delayed to match.
         valid_d <= (state == RUN);
         done    <= (state == SAT);
         if (state == SAT)
            result <= sat8(mac_acc);
      end
   end

   // Operand stage: zeros outside the data window keep the accumulator unchanged.
   assign mac_a     = valid_d ? x_rd : '0;
   assign mac_b     = valid_d ? w_rd : '0;
   assign mac_clr_n = (state == RUN) || (state == WAIT) || (state == SAT);
   assign busy      = (state != IDLE);

endmodule
